audio_pwm_engine: RTL

AUDIO_PWM_ENGINE -- requirements
Module: audio_pwm_engine

---
 rtl/audio_pwm_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/audio_pwm_engine.sv
// Audio PWM playback engine: unpacks FIFO words into one PWM duty value per period.
// Optional volume scaling is compiled in when AUDIO_PWM_ENGINE_VOLUME_EN is defined.
module audio_pwm_engine #(
  parameter int unsigned SAMPLE_W         = 8,
  parameter int unsigned SAMPLES_PER_WORD = 4,
  parameter int unsigned FIFO_DATA_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       aud_en,
`ifdef AUDIO_PWM_ENGINE_VOLUME_EN
  input  logic [3:0]                 aud_vol,
`endif
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic                       underflow_clr,
  output logic                       aud_pwm,
  output logic                       underflow,
  output logic                       busy
);

  localparam int unsigned SLOT_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
  localparam logic [SAMPLE_W-1:0] MIDSCALE  = SAMPLE_W'(1) << (SAMPLE_W - 1);
  localparam logic [SAMPLE_W-1:0] COUNT_MAX = {SAMPLE_W{1'b1}};
  localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(SAMPLES_PER_WORD - 1);

  if (FIFO_DATA_WIDTH != SAMPLE_W * SAMPLES_PER_WORD) begin : g_bad_width
    $error("audio_pwm_engine: FIFO_DATA_WIDTH must equal SAMPLE_W*SAMPLES_PER_WORD");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                     state, state_d;
  logic [SAMPLE_W-1:0]        count, count_d;
  logic [SAMPLE_W-1:0]        duty, duty_d;
  logic [SLOT_W-1:0]          slot, slot_d;
  logic [FIFO_DATA_WIDTH-1:0] word, word_d;
  logic                       underflow_d;
  logic                       pwm_d;
  logic                       period_end;
  logic                       uf_event;

  // Select one sample of a packed word; slot 0 lives in the LSBs.
  function automatic logic [SAMPLE_W-1:0] slot_sample(input logic [FIFO_DATA_WIDTH-1:0] w,
                                                      input logic [SLOT_W-1:0] idx);
    logic [SAMPLE_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < SAMPLES_PER_WORD; i++) begin
      if (idx == SLOT_W'(i)) s = w[i*SAMPLE_W +: SAMPLE_W];
    end
    return s;
  endfunction

  // Sample to duty conversion, applied once when the duty register loads.
  function automatic logic [SAMPLE_W-1:0] to_duty(input logic [SAMPLE_W-1:0] s);
`ifdef AUDIO_PWM_ENGINE_VOLUME_EN
    logic [SAMPLE_W+3:0] prod;
    prod = (SAMPLE_W+4)'(s) * (SAMPLE_W+4)'({1'b0, aud_vol} + 5'd1);
    return SAMPLE_W'(prod >> 4);
`else
    return s;
`endif
  endfunction

  assign busy = (state == RUN);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      count     <= '0;
      slot      <= '0;
      duty      <= MIDSCALE;
      word      <= '0;
      aud_pwm   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      slot      <= slot_d;
      duty      <= duty_d;
      word      <= word_d;
      aud_pwm   <= pwm_d;
      underflow <= underflow_d;
    end
  end

  // Next-state, period bookkeeping and the FWFT pop strobe.
  always_comb begin
    state_d    = state;
    count_d    = '0;
    slot_d     = slot;
    duty_d     = duty;
    word_d     = word;
    fifo_rd_en = 1'b0;
    uf_event   = 1'b0;
    period_end = (count == COUNT_MAX);

    case (state)
      IDLE: begin
        if (aud_en) begin
          state_d = RUN;
          slot_d  = LAST_SLOT;
          duty_d  = MIDSCALE;
        end
      end
      RUN: begin
        count_d = count + SAMPLE_W'(1);
        if (period_end) begin
          if (!aud_en) begin
            state_d = IDLE;
          end else if (slot == LAST_SLOT) begin
            slot_d = '0;
            if (!fifo_empty) begin
              fifo_rd_en = 1'b1;
              word_d     = fifo_rd_data;
              duty_d     = to_duty(fifo_rd_data[SAMPLE_W-1:0]);
            end else begin
              uf_event = 1'b1;
              word_d   = {SAMPLES_PER_WORD{MIDSCALE}};
              duty_d   = to_duty(MIDSCALE);
            end
          end else begin
            slot_d = slot + SLOT_W'(1);
            duty_d = to_duty(slot_sample(word, slot + SLOT_W'(1)));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new underflow event takes priority over a clear in the same cycle.
    underflow_d = uf_event | (underflow & ~underflow_clr);
    pwm_d       = (state == RUN) && (count < duty);
  end

endmodule
